// File: rtl/sd_sector_sched.sv
// SD multi-sector read scheduler: issues per-sector read commands,
// forwards reader bytes one cycle late, and guards each job with a timeout.
module sd_sector_sched #(
   parameter int unsigned SECTOR_BYTES = 512,
   parameter int unsigned TMO_CYC      = 1000000
) (
   input  logic        SD_clk,
   input  logic        sd_rstn,
   input  logic        init_done,
   input  logic        start,
   input  logic [31:0] start_sector,
   input  logic [15:0] sector_count,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ack,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic        busy,
   output logic [15:0] sectors_done,
   output logic        done,
   output logic        err
);

   localparam int BW = $clog2(SECTOR_BYTES + 1);
   localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [BW-1:0] BLAST = BW'(SECTOR_BYTES - 1);
   localparam logic [TW-1:0] TLAST = TW'(TMO_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_INIT,
      ST_REQ,
      ST_XFER,
      ST_NEXT,
      ST_DONE,
      ST_ERR
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   sdone_q, sdone_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_q, err_d;
   logic          pixv_q, pixv_d;
   logic [7:0]    pixd_q, pixd_d;

   always_ff @(posedge SD_clk or negedge sd_rstn) begin
      if (!sd_rstn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         sdone_q <= '0;
         bcnt_q  <= '0;
         tmr_q   <= '0;
         err_q   <= 1'b0;
         pixv_q  <= 1'b0;
         pixd_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         sdone_q <= sdone_d;
         bcnt_q  <= bcnt_d;
         tmr_q   <= tmr_d;
         err_q   <= err_d;
         pixv_q  <= pixv_d;
         pixd_q  <= pixd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      sdone_d = sdone_q;
      bcnt_d  = bcnt_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      pixv_d  = 1'b0;
      pixd_d  = pixd_q;

      // bytes are only meaningful while a sector is streaming
      if (state_q == ST_XFER && byte_valid) begin
         pixv_d = 1'b1;
         pixd_d = byte_data;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = start_sector;
               cnt_d   = sector_count;
               err_d   = 1'b0;
               sdone_d = '0;
               tmr_d   = '0;
               bcnt_d  = '0;
               if (sector_count == 16'd0) begin
                  state_d = ST_DONE;
               end else if (init_done) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_WAIT_INIT;
               end
            end
         end
         ST_WAIT_INIT: begin
            if (init_done) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!init_done) begin
               state_d = ST_ERR;
            end else if (rd_ack) begin
               state_d = ST_XFER;
               bcnt_d  = '0;
               tmr_d   = '0;
            end else if (tmr_q == TLAST) begin
               state_d = ST_ERR;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         ST_XFER: begin
            // a byte arriving on the expiry cycle still counts as progress
            if (!init_done) begin
               state_d = ST_ERR;
            end else if (byte_valid) begin
               bcnt_d = bcnt_q + BW'(1);
               tmr_d  = '0;
               if (bcnt_q == BLAST) begin
                  state_d = ST_NEXT;
               end
            end else if (tmr_q == TLAST) begin
               state_d = ST_ERR;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         ST_NEXT: begin
            sdone_d = sdone_q + 16'd1;
            addr_d  = addr_q + 32'd1;
            if (!init_done) begin
               state_d = ST_ERR;
            end else if (sdone_q + 16'd1 == cnt_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ERR) begin
         err_d = 1'b1;
      end
   end

   assign rd_req       = (state_q == ST_REQ);
   assign rd_addr      = addr_q;
   assign pix_valid    = pixv_q;
   assign pix_data     = pixd_q;
   assign busy         = (state_q == ST_WAIT_INIT) || (state_q == ST_REQ) ||
                         (state_q == ST_XFER) || (state_q == ST_NEXT);
   assign sectors_done = sdone_q;
   assign done         = (state_q == ST_DONE);
   assign err          = err_q;

endmodule

// File: tb/tb_sd_sector_sched.sv
// Bench for sd_sector_sched: job table, byte scoreboard, timeout and
// reset corner sequences.
`timescale 1ns/1ps
module tb_sd_sector_sched;

   logic        SD_clk = 1'b0;
   logic        sd_rstn = 1'b0;
   logic        init_done = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_sector = '0;
   logic [15:0] sector_count = '0;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_ack = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        busy;
   logic [15:0] sectors_done;
   logic        done;
   logic        err;

   sd_sector_sched #(
      .SECTOR_BYTES(512),
      .TMO_CYC(16)
   ) dut (
      .SD_clk(SD_clk),
      .sd_rstn(sd_rstn),
      .init_done(init_done),
      .start(start),
      .start_sector(start_sector),
      .sector_count(sector_count),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_ack(rd_ack),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .pix_valid(pix_valid),
      .pix_data(pix_data),
      .busy(busy),
      .sectors_done(sectors_done),
      .done(done),
      .err(err)
   );

   always #5 SD_clk = ~SD_clk;

   typedef struct {
      logic [7:0] d;
      int         cyc;
   } pix_t;

   typedef struct {
      logic [31:0] sec;
      logic [15:0] n;
      int          idelay;
      logic [15:0] exp_sd;
      logic [31:0] exp_last;
   } vec_t;

   pix_t exp_q[$];
   pix_t obs_q[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   rdreq_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge SD_clk) cyc <= cyc + 1;

   always @(negedge SD_clk) begin
      if (pix_valid) obs_q.push_back('{d: pix_data, cyc: cyc});
      if (done) done_cnt++;
      if (rd_req) rdreq_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge SD_clk);
      #1;
   endtask

   task automatic send_bytes(input int nb);
      for (int i = 0; i < nb; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'($urandom);
         exp_q.push_back('{d: byte_data, cyc: cyc});
         tick();
      end
      byte_valid = 1'b0;
   endtask

   task automatic check_pix();
      pix_t o;
      pix_t e;
      chk("pix_count", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk("pix_data", o.d, e.d);
         chk("pix_latency", o.cyc, e.cyc + 1);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_rdreq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rd_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("rd_req_wait", ok, 1);
   endtask

   task automatic serve_sector(input logic [31:0] addr, input int nb,
                               output bit ok, output logic [31:0] seen);
      wait_rdreq(ok);
      seen = rd_addr;
      if (!ok) return;
      chk("rd_addr", rd_addr, addr);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("rd_req_drop", rd_req, 0);
      send_bytes(nb);
   endtask

   task automatic run_job(input vec_t v);
      int          d0;
      int          r0;
      bit          ok;
      logic [31:0] last;
      d0 = done_cnt;
      last = '0;
      init_done    = (v.idelay == 0);
      start        = 1'b1;
      start_sector = v.sec;
      sector_count = v.n;
      tick();
      start        = 1'b0;
      start_sector = 32'hDEAD_BEEF;
      sector_count = 16'h0007;
      chk("busy_after_start", busy, 1);
      if (v.idelay > 0) begin
         r0 = rdreq_cnt;
         repeat (v.idelay) tick();
         chk("no_req_before_init", rdreq_cnt - r0, 0);
         chk("busy_wait_init", busy, 1);
         init_done = 1'b1;
      end
      for (int k = 0; k < int'(v.n); k++) begin
         serve_sector(v.sec + 32'(k), 512, ok, last);
         if (!ok) return;
      end
      for (int i = 0; i < 10; i++) begin
         if (done) break;
         tick();
      end
      chk("done_seen", done, 1);
      chk("busy_in_done", busy, 0);
      tick();
      chk("done_pulses", done_cnt - d0, 1);
      chk("last_addr", last, v.exp_last);
      chk("sectors_done", sectors_done, v.exp_sd);
      chk("err_clear", err, 0);
      chk("busy_end", busy, 0);
      check_pix();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[4];
      vec_t        post;
      int          d0;
      int          r0;
      bit          ok;
      logic [31:0] seen;

      tbl[0] = '{sec: 32'h0000_0100, n: 16'd2, idelay: 0,
                 exp_sd: 16'd2, exp_last: 32'h0000_0101};
      tbl[1] = '{sec: 32'hFFFF_FFFF, n: 16'd2, idelay: 0,
                 exp_sd: 16'd2, exp_last: 32'h0000_0000};
      tbl[2] = '{sec: 32'h0000_0055, n: 16'd1, idelay: 50,
                 exp_sd: 16'd1, exp_last: 32'h0000_0055};
      tbl[3] = '{sec: 32'h0000_1234, n: 16'd3, idelay: 0,
                 exp_sd: 16'd3, exp_last: 32'h0000_1236};

      #3;
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_sectors_done", sectors_done, 0);
      tick();
      tick();
      sd_rstn = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) run_job(tbl[i]);

      // timeout: stall, byte on the expiry cycle, stall again
      init_done    = 1'b1;
      d0           = done_cnt;
      start        = 1'b1;
      start_sector = 32'h10;
      sector_count = 16'd1;
      tick();
      start = 1'b0;
      serve_sector(32'h10, 50, ok, seen);
      repeat (15) tick();
      chk("tmo_pre_err", err, 0);
      chk("tmo_pre_busy", busy, 1);
      send_bytes(1);
      repeat (15) tick();
      chk("tmo_byte_wins_err", err, 0);
      chk("tmo_byte_wins_busy", busy, 1);
      tick();
      chk("tmo_err", err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_rd_req", rd_req, 0);
      tick();
      chk("tmo_err_sticky", err, 1);
      chk("tmo_sectors_done", sectors_done, 0);
      chk("tmo_no_done", done_cnt - d0, 0);
      check_pix();

      // zero-length job
      r0           = rdreq_cnt;
      d0           = done_cnt;
      start        = 1'b1;
      start_sector = 32'h77;
      sector_count = 16'd0;
      tick();
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_err_cleared", err, 0);
      tick();
      chk("zero_done_low", done, 0);
      chk("zero_no_req", rdreq_cnt - r0, 0);
      chk("zero_pulses", done_cnt - d0, 1);
      chk("zero_sectors_done", sectors_done, 0);

      // start while busy, then reset mid-transfer
      d0           = done_cnt;
      start        = 1'b1;
      start_sector = 32'h200;
      sector_count = 16'd2;
      tick();
      start = 1'b0;
      wait_rdreq(ok);
      start        = 1'b1;
      start_sector = 32'h999;
      sector_count = 16'd5;
      tick();
      start = 1'b0;
      chk("busy_start_addr", rd_addr, 32'h200);
      chk("busy_start_req", rd_req, 1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      send_bytes(100);
      tick();
      @(negedge SD_clk);
      #1;
      sd_rstn = 1'b0;
      #1;
      chk("arst_rd_req", rd_req, 0);
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_pix_valid", pix_valid, 0);
      chk("arst_pix_data", pix_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_sectors_done", sectors_done, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err, 0);
      tick();
      sd_rstn = 1'b1;
      chk("arst_no_done", done_cnt - d0, 0);
      check_pix();
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      tick();
      byte_valid = 1'b0;
      chk("stray_pix_valid", pix_valid, 0);
      tick();
      check_pix();

      post = '{sec: 32'h0000_0300, n: 16'd1, idelay: 0,
               exp_sd: 16'd1, exp_last: 32'h0000_0300};
      run_job(post);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
